// File: rtl/if_fetch.sv
// Instruction fetch stage: drives the ROM and queues {pc, instr} for decode.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_misalign.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic        rom_ready,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_misalign
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_FULL,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [31:0]   r_buf_pc  [BUF_DEPTH];
  logic [31:0]   r_buf_ins [BUF_DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_misalign;
  logic [31:0]   w_redir_pc;
  logic [CW-1:0] w_cnt_nxt;

`ifdef IF_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign     = (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc     = redirect_pc;
  assign fetch_misalign = r_misalign;
`else
  assign w_misalign     = 1'b0;
  assign w_redir_pc     = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_misalign = 1'b0;
`endif

  assign w_push    = rom_en & rom_ready;
  assign w_pop     = id_valid & id_ready;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign rom_addr = r_pc;
  assign id_pc    = r_buf_pc[r_head];
  assign id_instr = r_buf_ins[r_head];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a redirect wins over everything but reset
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)
      w_state_nxt = w_misalign ? S_HALT : S_FETCH;
    else if (r_state != S_HALT)
      w_state_nxt = (w_cnt_nxt == DEPTH_C) ? S_FULL : S_FETCH;
  end

  // Output logic
  always_comb begin
    rom_en   = 1'b0;
    id_valid = 1'b0;
    if (!rst) begin
      rom_en   = (r_state == S_FETCH) && (r_count < DEPTH_C)
                 && !redirect_valid;
      id_valid = (r_count != '0) && !redirect_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (redirect_valid) begin
      r_pc    <= w_redir_pc;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_cnt_nxt;
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                 r_misalign <= 1'b0;
    else if (redirect_valid) r_misalign <= w_misalign;
  end
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]  <= r_pc;
      r_buf_ins[r_tail] <= rom_data;
    end
  end

endmodule
